// File: rtl/buffer_qsize_pingpong_ctrl.sv
// Ping-pong controller for a two-bank QSIZE buffer RAM: the producer fills one half
// while the consumer reads the other; banks swap when filled / released.

package buffer_qsize_pkg;
  localparam int BUFFER_READ_LATENCY = 2;
  localparam int QSIZE = 16;
endpackage

module buffer_qsize_pingpong_ctrl
  import buffer_qsize_pkg::*;
#(
  parameter int DEPTH        = 512,
  parameter int READ_LATENCY = BUFFER_READ_LATENCY,
  parameter int WIDTH        = QSIZE,
  localparam int DEPTHAD     = $clog2(DEPTH),
  localparam int BLOCK_LEN   = DEPTH / 2,
  localparam int OFFAD       = $clog2(BLOCK_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  input  logic [WIDTH-1:0]   wr_data,
  output logic               wr_ready,
  input  logic               rd_req,
  input  logic [OFFAD-1:0]   rd_offset,
  input  logic               rd_done,
  output logic               rd_bank_ready,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_data_valid,
  output logic [DEPTHAD-1:0] ram_waddr,
  output logic               ram_wren,
  output logic [WIDTH-1:0]   ram_wdata,
  output logic [DEPTHAD-1:0] ram_raddr,
  input  logic [WIDTH-1:0]   ram_rdata,
  output logic [1:0]         full_count,
  output logic               err_underrun
);

  logic [1:0]            full_reg;
  logic [1:0]            full_next;
  logic                  wb_reg;
  logic [OFFAD-1:0]      wo_reg;
  logic                  rb_reg;
  logic [READ_LATENCY:0] vld_sr_reg;
  logic [1:0]            full_count_reg;
  logic                  ram_wren_reg;
  logic [DEPTHAD-1:0]    ram_waddr_reg;
  logic [WIDTH-1:0]      ram_wdata_reg;
  logic [DEPTHAD-1:0]    ram_raddr_reg;
  logic                  err_reg;

  logic wr_accept;
  logic bank_done;
  logic rd_accept;
  logic rd_release;

  assign wr_ready      = !rst && !full_reg[wb_reg];
  assign rd_bank_ready = full_reg[rb_reg];
  assign wr_accept     = wr_valid && wr_ready;
  assign bank_done     = wr_accept && (wo_reg == OFFAD'(BLOCK_LEN - 1));
  assign rd_accept     = rd_req && rd_bank_ready;
  assign rd_release    = rd_done && rd_bank_ready;

  // Fill and release always target different banks, so both updates can apply at once.
  always_comb begin
    full_next = full_reg;
    if (bank_done)  full_next[wb_reg] = 1'b1;
    if (rd_release) full_next[rb_reg] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg       <= '0;
      full_count_reg <= '0;
      wb_reg         <= 1'b0;
      wo_reg         <= '0;
      rb_reg         <= 1'b0;
      vld_sr_reg     <= '0;
      ram_wren_reg   <= 1'b0;
      ram_waddr_reg  <= '0;
      ram_wdata_reg  <= '0;
      ram_raddr_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      full_reg       <= full_next;
      full_count_reg <= {1'b0, full_next[0]} + {1'b0, full_next[1]};
      ram_wren_reg   <= wr_accept;
      if (wr_accept) begin
        ram_waddr_reg <= {wb_reg, wo_reg};
        ram_wdata_reg <= wr_data;
        wo_reg        <= bank_done ? '0 : wo_reg + 1'b1;
      end
      if (bank_done) wb_reg <= ~wb_reg;
      // The read is captured against the old rb before a same-cycle release flips it.
      if (rd_accept) ram_raddr_reg <= {rb_reg, rd_offset};
      if (rd_release) rb_reg <= ~rb_reg;
      vld_sr_reg <= {vld_sr_reg[READ_LATENCY-1:0], rd_accept};
      if ((rd_req || rd_done) && !rd_bank_ready) err_reg <= 1'b1;
    end
  end

  assign ram_wren      = ram_wren_reg;
  assign ram_waddr     = ram_waddr_reg;
  assign ram_wdata     = ram_wdata_reg;
  assign ram_raddr     = ram_raddr_reg;
  assign rd_data       = ram_rdata;
  assign rd_data_valid = vld_sr_reg[READ_LATENCY];
  assign full_count    = full_count_reg;
  assign err_underrun  = err_reg;

endmodule
